// File: rtl/serial_subtractor_4_bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_4_bit_pkg;

    localparam int SERIAL_SUB_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_4_bit_fullsub.sv
// One-bit full subtractor (A - B - Bin) built from gate primitives.
module fullsubtractor_gate_level (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    wire a_xor_b;
    wire a_n;
    wire a_xnor_b;
    wire brw_gen;
    wire brw_prop;
    wire d_w;
    wire bout_w;

    xor g_axb  (a_xor_b, A, B);
    xor g_diff (d_w, a_xor_b, Bin);
    not g_an   (a_n, A);
    and g_gen  (brw_gen, a_n, B);
    // Incoming borrow passes through only when the two operand bits are equal.
    not g_xn   (a_xnor_b, a_xor_b);
    and g_prop (brw_prop, a_xnor_b, Bin);
    or  g_bout (bout_w, brw_gen, brw_prop);

    assign D    = d_w;
    assign Bout = bout_w;

endmodule

// File: rtl/serial_subtractor_4_bit.sv
// Bit-serial subtractor z = x - y - bin, one bit per clock through a single full-subtract cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor_4_bit
    import serial_subtractor_4_bit_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic diff_bit;
    logic borrow_bit;

    fullsubtractor_gate_level u_fs (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Bin  (br_q),
        .D    (diff_bit),
        .Bout (borrow_bit)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = x;
                    b_d     = y;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = borrow_bit;
                res_d = {diff_bit, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                // Publish the result on the final bit so it is already stable while done is high.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    z_d     = {diff_bit, res_q[WIDTH-1:1]};
                    bout_d  = borrow_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d   = br_q ^ borrow_bit;
`endif
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_SHIFT);
    assign done  = (state_q == ST_FINISH);
    assign z     = z_q;
    assign bout  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_4_bit.sv
// Scoreboard bench for serial_subtractor_4_bit; exercises ovf when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_4_bit;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] z;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] z;
    logic         bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    serial_subtractor_4_bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .bout  (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned wrap-around difference, borrow as sign of the true difference,
    // overflow as the signed difference falling outside the W-bit range.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        int   d;
        int   sa;
        int   sbv;
        int   sd;
        d      = int'(a) - int'(b) - int'(c);
        e.z    = W'(d);
        e.bout = (d < 0);
        sa     = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sbv    = b[W-1] ? int'(b) - (1 << W) : int'(b);
        sd     = sa - sbv - int'(c);
        e.ovf  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_done got z=%h bout=%b required no done", z, bout);
            end else begin
                mon_e = sb.pop_front();
                if (z !== mon_e.z || bout !== mon_e.bout
`ifdef SERIAL_SUB_OVERFLOW_EN
                    || ovf !== mon_e.ovf
`endif
                   ) begin
                    failures++;
                    $display("FAIL sb_result got z=%h bout=%b required z=%h bout=%b",
                             z, bout, mon_e.z, mon_e.bout);
`ifdef SERIAL_SUB_OVERFLOW_EN
                    $display("FAIL sb_ovf got ovf=%b required ovf=%b", ovf, mon_e.ovf);
`endif
                end
            end
        end
    end

    task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
        if (ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL issue_ready_timeout got ready=%b required 1", ready);
        end
        x     = a;
        y     = b;
        bin   = c;
        start = 1'b1;
        @(posedge clk);
        sb.push_back(model(a, b, c));
        #1 start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (sb.size() != 0 || ready !== 1'b1); i++) @(negedge clk);
        checks++;
        if (sb.size() != 0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_drain got pending=%0d ready=%b required pending=0 ready=1",
                     name, sb.size(), ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ready, busy, done, z, bout} !== {3'b100, {W{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got r/b/d=%b%b%b z=%h bout=%b required 100 z=0 bout=0",
                     ready, busy, done, z, bout);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got r/b/d=%b%b%b required 100", ready, busy, done);
        end
    endtask

    task automatic test_latency();
        logic [W-1:0] z_prev;
        int           dc0;
        z_prev = z;
        dc0    = done_cnt;
        @(negedge clk);
        x = 4'd9; y = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        sb.push_back(model(4'd9, 4'd3, 1'b0));
        for (int j = 0; j <= W; j++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (j < W) begin
                if (busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0 || z !== z_prev) begin
                    failures++;
                    $display("FAIL shift_phase%0d got r/b/d=%b%b%b z=%h required 010 z=%h",
                             j, ready, busy, done, z, z_prev);
                end
            end else begin
                if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
                    failures++;
                    $display("FAIL done_timing got r/b/d=%b%b%b required 001", ready, busy, done);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || z !== 4'd6 || bout !== 1'b0 || done_cnt != dc0 + 1) begin
            failures++;
            $display("FAIL ready_return got ready=%b done=%b z=%h bout=%b dones=%0d required 1 0 6 0 1",
                     ready, done, z, bout, done_cnt - dc0);
        end
    endtask

    task automatic test_directed();
        issue_op(4'd3, 4'd9, 1'b0);
        drain("sub_neg");
        checks++;
        if (z !== 4'hA || bout !== 1'b1) begin
            failures++;
            $display("FAIL sub_neg got z=%h bout=%b required z=a bout=1", z, bout);
        end
        issue_op(4'd0, 4'd0, 1'b1);
        drain("bin_only");
        checks++;
        if (z !== 4'hF || bout !== 1'b1) begin
            failures++;
            $display("FAIL bin_only got z=%h bout=%b required z=f bout=1", z, bout);
        end
        issue_op(4'hF, 4'hF, 1'b0);
        drain("equal_max");
        checks++;
        if (z !== 4'h0 || bout !== 1'b0) begin
            failures++;
            $display("FAIL equal_max got z=%h bout=%b required z=0 bout=0", z, bout);
        end
    endtask

    task automatic test_ignored_start();
        int dc0;
        dc0 = done_cnt;
        issue_op(4'd5, 4'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        x = 4'd0; y = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("ign_busy");
        repeat (W + 2) @(negedge clk);
        checks++;
        if (z !== 4'd4 || bout !== 1'b0 || done_cnt != dc0 + 1) begin
            failures++;
            $display("FAIL ign_busy got z=%h bout=%b dones=%0d required z=4 bout=0 dones=1",
                     z, bout, done_cnt - dc0);
        end
        dc0 = done_cnt;
        issue_op(4'd2, 4'd1, 1'b0);
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        x = 4'd0; y = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || z !== 4'd1 || done_cnt != dc0 + 1) begin
            failures++;
            $display("FAIL ign_finish got ready=%b busy=%b z=%h dones=%0d required 1 0 1 1",
                     ready, busy, z, done_cnt - dc0);
        end
    endtask

    task automatic test_reset_abort();
        int dc0;
        dc0 = done_cnt;
        issue_op(4'd12, 4'd4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({ready, busy, done, z, bout} !== {3'b100, {W{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL abort_state got r/b/d=%b%b%b z=%h bout=%b required 100 z=0 bout=0",
                     ready, busy, done, z, bout);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (W + 3) @(negedge clk);
        checks++;
        if (done_cnt != dc0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_no_done got dones=%0d ready=%b required 0 1", done_cnt - dc0, ready);
        end
        issue_op(4'd12, 4'd4, 1'b0);
        drain("abort_retry");
        checks++;
        if (z !== 4'd8 || bout !== 1'b0) begin
            failures++;
            $display("FAIL abort_retry got z=%h bout=%b required z=8 bout=0", z, bout);
        end
    endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
    task automatic test_overflow();
        issue_op(4'd8, 4'd1, 1'b0);
        drain("ovf_set");
        checks++;
        if (z !== 4'd7 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got z=%h ovf=%b required z=7 ovf=1", z, ovf);
        end
        issue_op(4'd7, 4'd1, 1'b0);
        drain("ovf_clr");
        checks++;
        if (z !== 4'd6 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr got z=%h ovf=%b required z=6 ovf=0", z, ovf);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int dc0;
        dc0 = done_cnt;
        for (int n = 0; n < 16; n++) begin
            issue_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
                     1'($urandom_range(0, 1)));
            @(negedge clk);
            x   = W'($urandom_range(0, (1 << W) - 1));
            y   = W'($urandom_range(0, (1 << W) - 1));
            bin = 1'($urandom_range(0, 1));
        end
        drain("b2b");
        checks++;
        if (done_cnt != dc0 + 16) begin
            failures++;
            $display("FAIL b2b_count got dones=%0d required 16", done_cnt - dc0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        bin   = 1'b0;
        test_reset();
        test_latency();
        test_directed();
        test_ignored_start();
        test_reset_abort();
`ifdef SERIAL_SUB_OVERFLOW_EN
        test_overflow();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
